lsb_mem_port: RTL and testbench

LSB_MEM_PORT -- requirements
Module: lsb_mem_port

---
 rtl/lsb_mem_port_if.sv | 42 ++++
 rtl/lsb_mem_port.sv | 126 ++++++++++++
 tb/tb_lsb_mem_port.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/lsb_mem_port_if.sv
// Bundled request, memory-controller and result signals of the LSB memory port.
// The master modport is the port block itself and the slave modport is its environment.
interface lsb_mem_port_if #(
    parameter int ROB_TAG_W = 4
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_is_store;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic [ROB_TAG_W-1:0] req_tag;

    logic                 mem_req;
    logic                 mem_r_nw;
    logic [1:0]           mem_work_type;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_wdata;
    logic                 mem_recive;
    logic                 mem_done;
    logic [31:0]          mem_rdata;

    logic                 res_valid;
    logic [ROB_TAG_W-1:0] res_tag;
    logic [31:0]          res_data;

    modport master (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
        output req_ready,
        output mem_req, mem_r_nw, mem_work_type, mem_addr, mem_wdata,
        input  mem_recive, mem_done, mem_rdata,
        output res_valid, res_tag, res_data
    );

    modport slave (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, req_tag,
        input  req_ready,
        input  mem_req, mem_r_nw, mem_work_type, mem_addr, mem_wdata,
        output mem_recive, mem_done, mem_rdata,
        input  res_valid, res_tag, res_data
    );
endinterface

// File: rtl/lsb_mem_port.sv
// Single-outstanding memory port between the LSB head and the memory controller.
// One access at a time: accept, issue until the controller takes it, wait for completion, report.
module lsb_mem_port #(
    parameter int ROB_TAG_W = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               _clear,
    lsb_mem_port_if.master     bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]           state_q,     state_d;
    logic                 is_store_q,  is_store_d;
    logic [2:0]           funct3_q,    funct3_d;
    logic [1:0]           work_type_q, work_type_d;
    logic [31:0]          addr_q,      addr_d;
    logic [31:0]          wdata_q,     wdata_d;
    logic [ROB_TAG_W-1:0] tag_q,       tag_d;
    logic [31:0]          res_data_q,  res_data_d;

    // Access size encoding: byte count minus one, the 11 pattern treated as a word.
    function automatic logic [1:0] size_code(input logic [1:0] f);
        case (f)
            2'b00:   size_code = 2'd0;
            2'b01:   size_code = 2'd1;
            default: size_code = 2'd3;
        endcase
    endfunction

    // Pick the low-order bytes out of the left-justified read word and extend them.
    function automatic logic [31:0] load_ext(input logic [2:0] f, input logic [31:0] d);
        case (f)
            3'b000:  load_ext = {{24{d[31]}}, d[31:24]};
            3'b001:  load_ext = {{16{d[31]}}, d[31:16]};
            3'b100:  load_ext = {24'd0, d[31:24]};
            3'b101:  load_ext = {16'd0, d[31:16]};
            default: load_ext = d;
        endcase
    endfunction

    // Next-state and request-latch logic; a flush overrides every other event.
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        work_type_d = work_type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        tag_d       = tag_q;
        res_data_d  = res_data_q;
        if (_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && bus.req_ready) begin
                        is_store_d  = bus.req_is_store;
                        funct3_d    = bus.req_funct3;
                        work_type_d = size_code(bus.req_funct3[1:0]);
                        addr_d      = bus.req_addr;
                        wdata_d     = bus.req_wdata;
                        tag_d       = bus.req_tag;
                        state_d     = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    if (bus.mem_recive) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_done) begin
                        res_data_d = is_store_q ? 32'd0 : load_ext(funct3_q, bus.mem_rdata);
                        state_d    = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_RESP:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State registers: reset always wins, rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            work_type_q <= 2'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            tag_q       <= {ROB_TAG_W{1'b0}};
            res_data_q  <= 32'd0;
        end else if (rdy_in) begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            work_type_q <= work_type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            res_data_q  <= res_data_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.mem_req       = (state_q == S_ISSUE);
    assign bus.mem_r_nw      = is_store_q;
    assign bus.mem_work_type = work_type_q;
    assign bus.mem_addr      = addr_q;
    assign bus.mem_wdata     = wdata_q;
    assign bus.res_valid     = (state_q == S_RESP);
    assign bus.res_tag       = tag_q;
    assign bus.res_data      = res_data_q;
endmodule

// File: tb/tb_lsb_mem_port.sv
// Self-checking bench for lsb_mem_port: directed corner cases then random traffic,
// every cycle compared against a transaction-level model of the port.
module tb_lsb_mem_port;
    localparam int TW = 4;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    logic clear;
    int   n_vec = 0;
    int   n_err = 0;

    lsb_mem_port_if #(.ROB_TAG_W(TW)) bus ();

    lsb_mem_port #(.ROB_TAG_W(TW)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        ._clear (clear),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Model: an optional outstanding request, whether the controller took it, and a pending result.
    logic          m_busy, m_acc, m_resp, m_st;
    logic [2:0]    m_f3;
    logic [31:0]   m_addr, m_wdata, m_res;
    logic [TW-1:0] m_tag;

    function automatic int n_bytes(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] d);
        int     nb;
        longint v;
        nb = n_bytes(f3);
        v  = longint'(d) >> (32 - 8 * nb);
        if (!f3[2] && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        return v[31:0];
    endfunction

    task automatic model_step();
        if (rst) begin
            m_busy = 1'b0; m_acc = 1'b0; m_resp = 1'b0; m_st = 1'b0;
            m_f3 = 3'd0; m_addr = 32'd0; m_wdata = 32'd0; m_res = 32'd0; m_tag = '0;
        end else if (!rdy) begin
            m_busy = m_busy;
        end else if (clear) begin
            m_busy = 1'b0; m_acc = 1'b0; m_resp = 1'b0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (m_busy && !m_acc) begin
            if (bus.mem_recive) m_acc = 1'b1;
        end else if (m_busy) begin
            if (bus.mem_done) begin
                m_res  = m_st ? 32'd0 : model_load(m_f3, bus.mem_rdata);
                m_resp = 1'b1; m_busy = 1'b0; m_acc = 1'b0;
            end
        end else if (bus.req_valid) begin
            m_busy = 1'b1; m_st = bus.req_is_store; m_f3 = bus.req_funct3;
            m_addr = bus.req_addr; m_wdata = bus.req_wdata; m_tag = bus.req_tag;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("req_ready", 32'(bus.req_ready), 32'(!(m_busy || m_resp)));
        chk("mem_req", 32'(bus.mem_req), 32'(m_busy && !m_acc));
        chk("mem_r_nw", 32'(bus.mem_r_nw), 32'(m_st));
        chk("mem_work_type", 32'(bus.mem_work_type), 32'(n_bytes(m_f3) - 1));
        chk("mem_addr", bus.mem_addr, m_addr);
        chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("res_valid", 32'(bus.res_valid), 32'(m_resp));
        chk("res_tag", 32'(bus.res_tag), 32'(m_tag));
        chk("res_data", bus.res_data, m_res);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [TW-1:0] tag);
        bus.req_valid = 1'b1; bus.req_is_store = st; bus.req_funct3 = f3;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_tag = tag;
        cycle();
        bus.req_valid = 1'b0;
    endtask

    task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [TW-1:0] tag, input int delay,
                       input logic [31:0] rdata, input logic [31:0] exp_res, input logic [1:0] exp_wt);
        issue(st, f3, addr, wd, tag);
        chk("issue_mem_req", 32'(bus.mem_req), 32'd1);
        chk("issue_work_type", 32'(bus.mem_work_type), 32'(exp_wt));
        chk("issue_addr", bus.mem_addr, addr);
        chk("issue_r_nw", 32'(bus.mem_r_nw), 32'(st));
        if (st) chk("issue_wdata", bus.mem_wdata, wd);
        for (int i = 0; i < delay; i++) begin
            cycle();
            chk("held_mem_req", 32'(bus.mem_req), 32'd1);
        end
        bus.mem_recive = 1'b1;
        cycle();
        chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
        cycle();
        bus.mem_recive = 1'b0;
        chk("stray_accept", 32'(bus.mem_req), 32'd0);
        bus.mem_done = 1'b1; bus.mem_rdata = rdata;
        cycle();
        bus.mem_done = 1'b0;
        chk("resp_valid", 32'(bus.res_valid), 32'd1);
        chk("resp_data", bus.res_data, exp_res);
        chk("resp_tag", 32'(bus.res_tag), 32'(tag));
        chk("model_pin", m_res, exp_res);
        cycle();
        chk("resp_one_cycle", 32'(bus.res_valid), 32'd0);
        chk("back_idle", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        bus.req_valid = 1'b0; bus.req_is_store = 1'b0; bus.req_funct3 = 3'd0;
        bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_tag = '0;
        bus.mem_recive = 1'b0; bus.mem_done = 1'b0; bus.mem_rdata = 32'd0;
        cycle();
        cycle();
        rst = 1'b0;
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_res_data", bus.res_data, 32'd0);

        txn(1'b0, 3'b000, 32'h0000_1004, 32'd0, 4'd5, 0, 32'h8012_3456, 32'hFFFF_FF80, 2'd0);
        txn(1'b0, 3'b101, 32'h0000_2002, 32'd0, 4'd6, 1, 32'hBEEF_1234, 32'h0000_BEEF, 2'd1);
        txn(1'b0, 3'b001, 32'h0000_2002, 32'd0, 4'd7, 0, 32'hBEEF_1234, 32'hFFFF_BEEF, 2'd1);
        txn(1'b1, 3'b010, 32'h0003_0000, 32'hDEAD_BEEF, 4'd8, 5, 32'h1234_5678, 32'd0, 2'd3);
        txn(1'b0, 3'b100, 32'h0000_0007, 32'd0, 4'd9, 2, 32'h80FF_FFFF, 32'h0000_0080, 2'd0);
        txn(1'b0, 3'b010, 32'h0000_0100, 32'd0, 4'd15, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 2'd3);

        // Flush in WAIT coinciding with completion: no result.
        issue(1'b0, 3'b010, 32'h40, 32'd0, 4'd3);
        bus.mem_recive = 1'b1; cycle(); bus.mem_recive = 1'b0;
        clear = 1'b1; bus.mem_done = 1'b1; cycle(); clear = 1'b0; bus.mem_done = 1'b0;
        chk("clear_no_res", 32'(bus.res_valid), 32'd0);
        chk("clear_ready", 32'(bus.req_ready), 32'd1);
        chk("clear_mem_req", 32'(bus.mem_req), 32'd0);
        cycle();
        chk("clear_no_res_late", 32'(bus.res_valid), 32'd0);

        // Stall during ISSUE with an accept pulse that must be ignored.
        issue(1'b1, 3'b001, 32'h80, 32'h0000_5A5A, 4'd2);
        rdy = 1'b0; bus.mem_recive = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_mem_req", 32'(bus.mem_req), 32'd1);
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
        end
        rdy = 1'b1; cycle(); bus.mem_recive = 1'b0;
        chk("stall_accept", 32'(bus.mem_req), 32'd0);

        // Reset while waiting for completion.
        rst = 1'b1; cycle(); rst = 1'b0;
        chk("wait_rst_ready", 32'(bus.req_ready), 32'd1);
        chk("wait_rst_addr", bus.mem_addr, 32'd0);
        chk("wait_rst_wdata", bus.mem_wdata, 32'd0);
        chk("wait_rst_tag", 32'(bus.res_tag), 32'd0);
        bus.mem_done = 1'b1; cycle(); bus.mem_done = 1'b0;
        chk("wait_rst_no_res", 32'(bus.res_valid), 32'd0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] f3s [5];
            f3s[0] = 3'b000; f3s[1] = 3'b001; f3s[2] = 3'b010; f3s[3] = 3'b100; f3s[4] = 3'b101;
            rst   = ($urandom_range(0, 99) < 2);
            rdy   = ($urandom_range(0, 99) < 85);
            clear = ($urandom_range(0, 99) < 4);
            bus.req_valid    = $urandom_range(0, 1);
            bus.req_is_store = $urandom_range(0, 1);
            bus.req_funct3   = bus.req_is_store ? f3s[$urandom_range(0, 2)] : f3s[$urandom_range(0, 4)];
            bus.req_addr     = $urandom;
            bus.req_wdata    = $urandom;
            bus.req_tag      = TW'($urandom);
            bus.mem_recive   = ($urandom_range(0, 99) < 30);
            bus.mem_done     = ($urandom_range(0, 99) < 30);
            bus.mem_rdata    = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
